// File: rtl/pipelined_adder_pkg.sv
// ----------------------------------------------------------------------------
// pipelined_adder_pkg : segment-count and latency helpers for pipelined_adder
// rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package pipelined_adder_pkg;

   localparam int DEF_WIDTH     = 39;
   localparam int DEF_SEG_WIDTH = 13;

   function automatic int nseg(input int width, input int seg_width);
      return (width + seg_width - 1) / seg_width;
   endfunction

   function automatic int latency(input int n);
      return n + 1;
   endfunction

   // The most significant segment absorbs the remainder and may be narrower.
   function automatic int top_seg_width(input int width, input int seg_width);
      return width - (nseg(width, seg_width) - 1) * seg_width;
   endfunction

endpackage

`default_nettype wire

// File: rtl/adder_segment.sv
// ----------------------------------------------------------------------------
// adder_segment : combinational W-bit adder slice with carry in/out
// rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module adder_segment #(
   parameter int W = 13
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout
);

   always_comb begin
      {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
   end

endmodule

`default_nettype wire

// File: rtl/pipelined_adder.sv
// ----------------------------------------------------------------------------
// pipelined_adder : carry-segmented pipelined add/sub with valid/ready stream
// rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module pipelined_adder
   import pipelined_adder_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int SEG_WIDTH = DEF_SEG_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   sum
);

   localparam int NSEG  = nseg(WIDTH, SEG_WIDTH);
   localparam int TOP_W = top_seg_width(WIDTH, SEG_WIDTH);

   // word_q[k]: segments below k hold finished result bits, the rest still
   // hold operand A. word_q[NSEG] is therefore the complete result.
   logic [WIDTH-1:0] word_q   [NSEG+1];
   logic [WIDTH-1:0] word_d   [NSEG+1];
   logic [WIDTH-1:0] b_q      [NSEG];
   logic [WIDTH-1:0] b_d      [NSEG];
   logic [NSEG:0]    valid_q, valid_d;
   logic [NSEG:0]    sub_q,   sub_d;
   logic [NSEG:0]    carry_q, carry_d;   // [0] is the raw cin of the beat
   logic [WIDTH-1:0] seg_word [NSEG];
   logic [NSEG-1:0]  seg_cout;
   logic             en;

   assign en        = !valid_q[NSEG] || out_ready;
   assign in_ready  = en;
   assign out_valid = valid_q[NSEG];
   assign sum       = {carry_q[NSEG] ^ sub_q[NSEG], word_q[NSEG]};

   for (genvar s = 0; s < NSEG; s++) begin : g_seg
      localparam int LO = s * SEG_WIDTH;
      localparam int SW = (s == NSEG - 1) ? TOP_W : SEG_WIDTH;

      logic [SW-1:0]    b_eff;
      logic [SW-1:0]    seg_s;
      logic             c_in;
      logic             c_out;
      logic [WIDTH-1:0] nxt;

      assign b_eff = b_q[s][LO +: SW] ^ {SW{sub_q[s]}};

      if (s == 0) begin : g_first
         // Subtract is a + ~b + 1 with the borrow-in folded into the carry.
         assign c_in = carry_q[0] ^ sub_q[0];
      end else begin : g_chain
         assign c_in = carry_q[s];
      end

      adder_segment #(.W(SW)) u_seg (
         .a    (word_q[s][LO +: SW]),
         .b    (b_eff),
         .cin  (c_in),
         .s    (seg_s),
         .cout (c_out)
      );

      always_comb begin
         nxt            = word_q[s];
         nxt[LO +: SW]  = seg_s;
      end

      assign seg_word[s] = nxt;
      assign seg_cout[s] = c_out;
   end

   // Data registers only load behind a valid beat so the output word keeps
   // the last real result while bubbles pass through.
   always_comb begin
      valid_d = valid_q;
      sub_d   = sub_q;
      carry_d = carry_q;
      word_d  = word_q;
      b_d     = b_q;
      if (en) begin
         valid_d = {valid_q[NSEG-1:0], in_valid};
         if (in_valid) begin
            word_d[0]  = a;
            b_d[0]     = b;
            sub_d[0]   = sub;
            carry_d[0] = cin;
         end
         for (int s = 0; s < NSEG; s++) begin
            if (valid_q[s]) begin
               word_d[s+1]  = seg_word[s];
               sub_d[s+1]   = sub_q[s];
               carry_d[s+1] = seg_cout[s];
            end
         end
         for (int s = 1; s < NSEG; s++) begin
            if (valid_q[s-1]) begin
               b_d[s] = b_q[s-1];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         sub_q   <= '0;
         carry_q <= '0;
         for (int i = 0; i <= NSEG; i++) word_q[i] <= '0;
         for (int i = 0; i < NSEG; i++)  b_q[i]    <= '0;
      end else begin
         valid_q <= valid_d;
         sub_q   <= sub_d;
         carry_q <= carry_d;
         word_q  <= word_d;
         b_q     <= b_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pipelined_adder.sv
// ----------------------------------------------------------------------------
// tb_pipelined_adder : scoreboard bench for pipelined_adder, incl. parameter sweep
// rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_pipelined_adder;
   import pipelined_adder_pkg::*;

   int n_vec = 0;
   int n_bad = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                             input logic sub, input logic cin);
      logic [63:0] mask, aa, bb, r;
      mask = (64'd1 << w) - 64'd1;
      aa   = a & mask;
      bb   = b & mask;
      if (!sub) begin
         r = aa + bb + {63'd0, cin};
      end else begin
         r = (aa - bb - {63'd0, cin}) & mask;
         if (aa < bb + {63'd0, cin}) r = r | (64'd1 << w);
      end
      return r;
   endfunction

   // ---------------- main instance: WIDTH=39, SEG_WIDTH=13 ----------------
   logic        m_rst_n     = 1'b0;
   logic        m_in_valid  = 1'b0;
   logic        m_in_ready;
   logic [38:0] m_a         = '0;
   logic [38:0] m_b         = '0;
   logic        m_sub       = 1'b0;
   logic        m_cin       = 1'b0;
   logic        m_out_valid;
   logic        m_out_ready = 1'b1;
   logic [39:0] m_sum;
   logic [63:0] m_exp       = '0;
   logic [63:0] m_q[$];
   int          m_pushed    = 0;
   int          m_popped    = 0;

   pipelined_adder #(.WIDTH(39), .SEG_WIDTH(13)) u_dut (
      .clk       (clk),
      .rst_n     (m_rst_n),
      .in_valid  (m_in_valid),
      .in_ready  (m_in_ready),
      .a         (m_a),
      .b         (m_b),
      .sub       (m_sub),
      .cin       (m_cin),
      .out_valid (m_out_valid),
      .out_ready (m_out_ready),
      .sum       (m_sum)
   );

   always @(negedge clk) begin
      if (m_out_valid && m_out_ready) begin
         if (m_q.size() == 0) begin
            check_eq("main_spurious_out", 64'(m_out_valid), 64'd0);
         end else begin
            check_eq("main_sum", 64'(m_sum), m_q.pop_front());
            m_popped++;
         end
      end
      if (m_in_valid && m_in_ready) begin
         m_q.push_back(m_exp);
         m_pushed++;
      end
   end

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic m_send(input logic [38:0] a, input logic [38:0] b, input logic sub,
                         input logic cin, input logic [63:0] exp);
      int g = 0;
      m_a = a; m_b = b; m_sub = sub; m_cin = cin; m_exp = exp;
      m_in_valid = 1'b1;
      @(negedge clk);
      while (!m_in_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (g >= 100) check_eq("main_accept_timeout", 64'(m_in_ready), 64'd1);
      @(posedge clk);
      #1;
      m_in_valid = 1'b0;
   endtask

   task automatic m_send_rand(input logic sub);
      logic [63:0] ra, rb;
      logic        c;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      c  = 1'($urandom_range(0, 1));
      m_send(ra[38:0], rb[38:0], sub, c, ref_model(39, ra, rb, sub, c));
   endtask

   task automatic m_drain(input string tag);
      int g = 0;
      while ((m_q.size() != 0 || m_out_valid) && g < 100) begin
         @(posedge clk);
         #1;
         g++;
      end
      check_eq(tag, 64'(m_q.size()), 64'd0);
   endtask

   // ---------------- parameter sweep instances ----------------
   for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
      localparam int W   = (gi == 2) ? 1 : 39;
      localparam int S   = (gi == 0) ? 39 : ((gi == 1) ? 8 : 1);
      localparam int LAT = latency(nseg(W, S));

      logic         rst_n_s = 1'b0;
      logic         iv      = 1'b0;
      logic         ir;
      logic [W-1:0] a_s     = '0;
      logic [W-1:0] b_s     = '0;
      logic         sb      = 1'b0;
      logic         ci      = 1'b0;
      logic         ov;
      logic         orr     = 1'b1;
      logic [W:0]   sum_s;
      logic [63:0]  exp_s   = '0;
      logic [63:0]  q[$];
      bit           bp_on   = 1'b0;
      bit           done    = 1'b0;

      pipelined_adder #(.WIDTH(W), .SEG_WIDTH(S)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n_s),
         .in_valid  (iv),
         .in_ready  (ir),
         .a         (a_s),
         .b         (b_s),
         .sub       (sb),
         .cin       (ci),
         .out_valid (ov),
         .out_ready (orr),
         .sum       (sum_s)
      );

      always @(posedge clk) begin
         #1;
         orr = bp_on ? ($urandom_range(0, 3) != 0) : 1'b1;
      end

      always @(negedge clk) begin
         if (ov && orr) begin
            if (q.size() == 0) check_eq($sformatf("sweep%0d_spurious_out", gi), 64'(ov), 64'd0);
            else               check_eq($sformatf("sweep%0d_sum", gi), 64'(sum_s), q.pop_front());
         end
         if (iv && ir) q.push_back(exp_s);
      end

      initial begin
         int          cyc;
         int          g;
         logic [63:0] ra, rb;
         repeat (3) @(posedge clk);
         #1;
         rst_n_s = 1'b1;

         // latency probe: all-ones + 1 forces a carry through every segment
         a_s = '1; b_s = W'(1); sb = 1'b0; ci = 1'b0;
         exp_s = ref_model(W, 64'(a_s), 64'(b_s), sb, ci);
         iv = 1'b1;
         @(posedge clk);
         #1;
         iv  = 1'b0;
         cyc = 1;
         while (!ov && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
         end
         check_eq($sformatf("sweep%0d_latency", gi), 64'(cyc), 64'(LAT));

         bp_on = 1'b1;
         for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 4) == 0) begin
               @(posedge clk);
               #1;
            end else begin
               ra = {$urandom, $urandom};
               rb = {$urandom, $urandom};
               if ($urandom_range(0, 7) == 0) ra = '1;
               if ($urandom_range(0, 7) == 0) rb = '1;
               a_s = ra[W-1:0];
               b_s = rb[W-1:0];
               sb  = 1'($urandom_range(0, 1));
               ci  = 1'($urandom_range(0, 1));
               exp_s = ref_model(W, 64'(a_s), 64'(b_s), sb, ci);
               iv = 1'b1;
               @(negedge clk);
               g = 0;
               while (!ir && g < 200) begin
                  @(negedge clk);
                  g++;
               end
               if (g >= 200) check_eq($sformatf("sweep%0d_accept_timeout", gi), 64'(ir), 64'd1);
               @(posedge clk);
               #1;
               iv = 1'b0;
            end
         end
         bp_on = 1'b0;
         g = 0;
         while ((q.size() != 0 || ov) && g < 200) begin
            @(posedge clk);
            #1;
            g++;
         end
         check_eq($sformatf("sweep%0d_drain", gi), 64'(q.size()), 64'd0);
         done = 1'b1;
      end
   end

   // ---------------- main directed sequence ----------------
   initial begin
      int cyc;
      int run;
      int g;

      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_out_valid", 64'(m_out_valid), 64'd0);
      check_eq("rst_sum",       64'(m_sum),       64'd0);
      check_eq("rst_in_ready",  64'(m_in_ready),  64'd1);
      @(negedge clk);
      m_rst_n = 1'b1;
      @(posedge clk);
      #1;

      // carry ripple through all three segments, exact latency
      m_send(39'h7F_FFFF_FFFF, 39'd1, 1'b0, 1'b0, 64'h80_0000_0000);
      cyc = 1;
      while (!m_out_valid && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check_eq("latency", 64'(cyc), 64'd4);
      check_eq("carry_ripple_sum", 64'(m_sum), 64'h80_0000_0000);
      m_drain("drain_ripple");

      // directed add/sub boundaries, back to back
      m_send(39'd5, 39'd7, 1'b1, 1'b0, 64'hFF_FFFF_FFFE);
      m_send(39'd7, 39'd5, 1'b1, 1'b1, 64'h01);
      m_send(39'd0, 39'd0, 1'b1, 1'b1, 64'hFF_FFFF_FFFF);
      m_send(39'h7F_FFFF_FFFF, 39'h7F_FFFF_FFFF, 1'b0, 1'b1, 64'hFF_FFFF_FFFF);
      m_send(39'h12_3456_789A, 39'h12_3456_789A, 1'b1, 1'b0, 64'h0);
      m_send(39'h0, 39'h0, 1'b0, 1'b0, 64'h0);
      m_drain("drain_directed");

      // 8 back-to-back beats with alternating mode must leave as an unbroken run
      fork
         begin
            for (int i = 0; i < 8; i++) m_send_rand(1'(i % 2));
         end
         begin
            g = 0;
            while (!m_out_valid && g < 50) begin
               @(posedge clk);
               #1;
               g++;
            end
            run = 0;
            while (m_out_valid && run < 20) begin
               run++;
               @(posedge clk);
               #1;
            end
            check_eq("burst_run_length", 64'(run), 64'd8);
         end
      join
      m_drain("drain_burst");

      // stall: hold out_ready low for 5 cycles while a result is presented
      fork
         begin
            for (int i = 0; i < 6; i++) m_send_rand(1'($urandom_range(0, 1)));
         end
         begin
            g = 0;
            while (!m_out_valid && g < 50) begin
               @(posedge clk);
               #1;
               g++;
            end
            m_out_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
               @(posedge clk);
               #1;
               check_eq("stall_out_valid", 64'(m_out_valid), 64'd1);
               check_eq("stall_in_ready",  64'(m_in_ready),  64'd0);
               if (m_q.size() != 0) check_eq("stall_sum", 64'(m_sum), m_q[0]);
               else                 check_eq("stall_queue_empty", 64'(m_q.size()), 64'd1);
            end
            m_out_ready = 1'b1;
         end
      join
      m_drain("drain_stall");
      check_eq("no_loss_count", 64'(m_popped), 64'(m_pushed));

      // reset with three beats in flight
      m_send_rand(1'b0);
      m_send_rand(1'b1);
      m_send_rand(1'b0);
      m_rst_n = 1'b0;
      #1;
      check_eq("midrst_out_valid", 64'(m_out_valid), 64'd0);
      check_eq("midrst_sum",       64'(m_sum),       64'd0);
      m_q.delete();
      @(posedge clk);
      @(negedge clk);
      m_rst_n = 1'b1;
      run = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (m_out_valid) run++;
      end
      check_eq("post_reset_stale_beats", 64'(run), 64'd0);

      // pipeline usable again after reset
      m_send(39'h40_0000_0001, 39'h3F_FFFF_FFFF, 1'b0, 1'b0, 64'h80_0000_0000);
      m_drain("drain_after_reset");

      g = 0;
      while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && g < 30000) begin
         @(posedge clk);
         g++;
      end
      if (g >= 30000) check_eq("sweep_timeout", 64'(g), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
Parametrised, carry-segmented pipelined adder/subtractor; successor to the fixed-width registered benchmark adder. The carry chain is split into SEG_WIDTH-bit segments, one register stage per segment, so clock rate is set by SEG_WIDTH rather than WIDTH. Adds per-operation add/sub mode, carry-in, and a valid/ready stream handshake with backpressure. Sits between operand-source registers and a downstream result consumer in the arithmetic benchmark set.

Parameters:
WIDTH, 39, operand width in bits (>=1).
SEG_WIDTH, 13, carry-segment width (1..WIDTH); NSEG = ceil(WIDTH/SEG_WIDTH); top segment may be narrower.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat this cycle
a  in  WIDTH  operand A (unsigned)
b  in  WIDTH  operand B (unsigned)
sub  in  1  0 = add, 1 = subtract
cin  in  1  carry-in (add) / borrow-in (sub)
out_valid  out  1  result beat valid
out_ready  in  1  consumer accepts result
sum  out  WIDTH+1  result; bit WIDTH = carry-out (add) or borrow-out (sub)

Behaviour:
- Reset (rst_n low, async): all valid bits 0, out_valid=0, sum=0, all data regs 0. Release is synchronous to clk in effect; first accept possible on the first edge after release.
- Global advance: en = !out_valid || out_ready. in_ready = en (combinational). All pipeline regs, including valid bits, load only when en=1; otherwise every stage holds.
- Accept: beat captured when in_valid && in_ready. When en=1 and in_valid=0 a bubble (valid=0) enters; bubbles are not compressed.
- Stage 0: registers a, b, sub, cin, valid (input register, as in the prior generation).
- Stage k (1..NSEG): computes segment k-1: seg_a + (sub ? ~seg_b : seg_b) + c, where c for segment 0 = sub ? ~cin : cin, else carry-out of segment k-2 registered in stage k-1. Higher segments' operands are skewed forward; completed lower result bits are deskewed so all bits of one beat exit together.
- Output: sum[WIDTH-1:0] = concatenated segment results; sum[WIDTH] = final carry when sub=0, inverted final carry when sub=1.
- Arithmetic: sub=0: sum = a + b + cin (exact, WIDTH+1 bits). sub=1: sum[WIDTH-1:0] = (a - b - cin) mod 2^WIDTH; sum[WIDTH] = 1 iff a < b + cin.
- Latency: NSEG+1 cycles from accept to out_valid with no stalls; throughput 1 beat/cycle under out_ready=1.
- Stall: out_valid=1 && out_ready=0 -> sum and out_valid held stable, in_ready=0, no internal movement; resume with no loss/duplication.
- sum holds its last value when out_valid=0 (not cleared except by reset).
- Reset mid-operation: all in-flight beats discarded; no out_valid for them after release.
- Mixed sub/add beats back-to-back: each beat uses its own sub/cin, carried down the pipeline with its data.
- NSEG=1: single adder stage, latency 2.

Decomposition:
- Package pipelined_adder_pkg: function nseg(width, seg_width); function latency(nseg) = nseg+1; localparam top-segment width = WIDTH - (NSEG-1)*SEG_WIDTH.
- Sub-module adder_segment (parameter W): combinational W-bit add with cin/cout; instantiated per segment via generate, registers held in the parent.

Test Plan:
- WIDTH=39, SEG_WIDTH=13: a=0x7F_FFFF_FFFF, b=1, sub=0, cin=0 -> sum=0x80_0000_0000 exactly 4 cycles after accept (carry ripples through all 3 segments).
- sub=1, a=5, b=7, cin=0 -> sum[38:0]=0x7F_FFFF_FFFE, sum[39]=1; a=7, b=5, cin=1 -> sum=0x01, borrow 0.
- 8 consecutive random beats, alternating sub, out_ready=1 -> 8 consecutive out_valid cycles, each matching the reference model, in order.
- out_ready=0 for 5 cycles while out_valid=1 -> sum stable, in_ready=0; release -> remaining beats emerge in order, none dropped or repeated.
- Assert rst_n low for 1 cycle with 3 beats in flight -> out_valid=0, sum=0 immediately; no stale beats after release.
- Parameter sweep: SEG_WIDTH=39 (latency 2), SEG_WIDTH=8 (NSEG=5, top segment 7 bits, latency 6), WIDTH=1; 1000 random beats each vs model.
